// File: rtl/picosoc_regs_dump.sv
// Debug read-out engine: walks a (possibly wrapping) index range of the PicoSoC
// register file through one async read port and streams the words out.
module picosoc_regs_dump #(
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [4:0]  first_i,
  input  logic [4:0]  last_i,
  input  logic        abort_i,
  output logic [5:0]  raddr_o,
  input  logic [31:0] rdata_i,
  output logic        busy_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [4:0]  out_addr_o,
  output logic        out_last_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  idx_q;
  logic [4:0]  end_idx_q;
  logic        busy_q;
  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic [4:0]  out_addr_q;
  logic        out_last_q;
  logic        done_q;

  logic        load_s;
  logic        hs_s;
  logic        at_end_s;
  logic [31:0] word_d;

  // Load/handshake qualifiers and the word to capture (x0 optionally forced to zero)
  always_comb begin
    load_s   = 1'b0;
    hs_s     = out_valid_q && out_ready_i;
    at_end_s = (idx_q == end_idx_q);
    word_d   = rdata_i;
    if (state_q == ST_READ) begin
      load_s = !out_valid_q || out_ready_i;
    end else begin
      load_s = 1'b0;
    end
    if (ZERO_X0 && (idx_q == 5'd0)) begin
      word_d = 32'h0000_0000;
    end else begin
      word_d = rdata_i;
    end
  end

  // Dump sequencer with registered stream outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= 5'd0;
      end_idx_q   <= 5'd0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_addr_q  <= 5'd0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            idx_q     <= first_i;
            end_idx_q <= last_i;
            busy_q    <= 1'b1;
            state_q   <= ST_READ;
          end
        end
        ST_READ: begin
          // Abort wins over any load or handshake in the same cycle
          if (abort_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (load_s) begin
            out_data_q  <= word_d;
            out_addr_q  <= idx_q;
            out_last_q  <= at_end_s;
            out_valid_q <= 1'b1;
            if (at_end_s) begin
              state_q <= ST_DRAIN;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (abort_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (hs_s) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign raddr_o     = {1'b0, idx_q};
  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;
  assign out_last_o  = out_last_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_picosoc_regs_dump.sv
// Randomized self-checking bench for picosoc_regs_dump with a 32x32 register
// file model and a range-based expected-stream model.
module tb_picosoc_regs_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first;
  logic [4:0]  last;
  logic        abort;
  logic [5:0]  raddr;
  logic [31:0] rdata;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        out_last;
  logic        done;

  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] mem [32];

  int n_cmp = 0;
  int n_fail = 0;

  picosoc_regs_dump #(.ZERO_X0(1'b1)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .first_i(first), .last_i(last),
    .abort_i(abort), .raddr_o(raddr), .rdata_i(rdata), .busy_o(busy),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_addr_o(out_addr), .out_last_o(out_last), .done_o(done)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, combinational read
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr[4:0]];

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); we = 1'b1; waddr = a; wdata = d;
    @(negedge clk); we = 1'b0;
  endtask

  task automatic preload(input int mode);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = i[4:0];
      wdata = (mode == 0) ? (32'hA500_0000 + i) : $urandom;
      @(negedge clk);
    end
    we = 1'b0;
  endtask

  // Runs one dump and checks it against the range model; inj>0 pulses start while busy
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit bp, input int inj);
    logic [4:0]  ea[$];
    logic [31:0] ed[$];
    logic [4:0]  span;
    logic [4:0]  a;
    logic [31:0] pd;
    logic [4:0]  pa;
    logic        pl;
    bit          pv, pr, fin;
    int          n, k, cyc;
    span = l - f;
    n = int'(span) + 1;
    for (int i = 0; i < n; i++) begin
      a = f + i[4:0];
      ea.push_back(a);
      ed.push_back((a == 5'd0) ? 32'h0 : mem[a]);
    end
    @(negedge clk); start = 1'b1; first = f; last = l; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; first = 5'($urandom); last = 5'($urandom);
    cyc = 1; k = 0; fin = 1'b0; pv = 1'b0; pr = 1'b1;
    pd = '0; pa = '0; pl = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
    while (!fin && cyc < 400) begin
      if (done === 1'b1) begin
        n_cmp++;
        if (k != n) begin n_fail++; $display("FAIL word_count [%0d..%0d]: got %0d want %0d", f, l, k, n); end
        if (!bp) begin
          n_cmp++;
          if (cyc != n + 2) begin n_fail++; $display("FAIL done_latency [%0d..%0d]: got %0d want %0d", f, l, cyc, n + 2); end
        end
        fin = 1'b1;
      end else begin
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_during cyc %0d: got %b want 1", cyc, busy); end
        if (pv && !pr) begin
          n_cmp++;
          if ({out_valid, out_data, out_addr, out_last} !== {1'b1, pd, pa, pl}) begin
            n_fail++;
            $display("FAIL stall_stable cyc %0d: got v%b %h @%0d l%b want v1 %h @%0d l%b",
                     cyc, out_valid, out_data, out_addr, out_last, pd, pa, pl);
          end
        end
        start = (cyc == inj);
        if (cyc == inj) begin first = 5'($urandom); last = 5'($urandom); end
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid === 1'b1 && out_ready) begin
          n_cmp++;
          if (k >= n) begin
            n_fail++; $display("FAIL extra_word: got @%0d %h want none", out_addr, out_data);
          end else if ({out_addr, out_data, out_last} !== {ea[k], ed[k], (k == n - 1)}) begin
            n_fail++;
            $display("FAIL word %0d [%0d..%0d]: got @%0d %h l%b want @%0d %h l%b",
                     k, f, l, out_addr, out_data, out_last, ea[k], ed[k], (k == n - 1));
          end
          if (!bp) begin
            n_cmp++;
            if (cyc != k + 2) begin n_fail++; $display("FAIL word_timing %0d: got cyc %0d want %0d", k, cyc, k + 2); end
          end
          k++;
        end
        pv = (out_valid === 1'b1); pr = out_ready; pd = out_data; pa = out_addr; pl = out_last;
        @(negedge clk); cyc++;
      end
    end
    start = 1'b0;
    if (!fin) begin n_cmp++; n_fail++; $display("FAIL done_timeout [%0d..%0d]: got no done want done", f, l); end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL after_done: got done%b busy%b valid%b want 000", done, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; first = '0; last = '0; abort = 1'b0;
    out_ready = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({raddr, busy, out_valid, out_data, out_addr, out_last, done} !== 47'h0) begin
      n_fail++; $display("FAIL reset_values: got %h want 0", {raddr, busy, out_valid, out_data, out_addr, out_last, done});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({raddr, busy, out_valid, done} !== 9'h0) begin
      n_fail++; $display("FAIL idle_after_reset: got %h want 0", {raddr, busy, out_valid, done});
    end
  endtask

  task automatic test_basic();
    preload(0);
    run_dump(5'd3, 5'd6, 1'b0, -1);
  endtask

  task automatic test_wrap();
    write_reg(5'd0, 32'hDEAD_BEEF);
    run_dump(5'd30, 5'd1, 1'b0, -1);
    run_dump(5'd7, 5'd7, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    preload(1);
    run_dump(5'd0, 5'd31, 1'b1, -1);
  endtask

  task automatic test_abort_and_ignored_start();
    int hs;
    int cyc;
    hs = 0;
    @(negedge clk); start = 1'b1; first = 5'd0; last = 5'd31; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (hs < 5 && cyc < 50) begin
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (out_addr !== hs[4:0]) begin n_fail++; $display("FAIL abort_seq: got @%0d want @%0d", out_addr, hs); end
        hs++;
      end
      @(negedge clk); cyc++;
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_cmp++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL abort_clear: got valid%b busy%b want 00", out_valid, busy);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({done, busy, out_valid} !== 3'b000) begin
        n_fail++; $display("FAIL abort_quiet cyc %0d: got done%b busy%b valid%b want 000", i, done, busy, out_valid);
      end
      @(negedge clk);
    end
    run_dump(5'd2, 5'd9, 1'b0, 4);
    run_dump(5'd20, 5'd3, 1'b1, 7);
  endtask

  task automatic test_reset_mid_dump();
    @(negedge clk); start = 1'b1; first = 5'd0; last = 5'd31; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({raddr, busy, out_valid, out_data, out_addr, out_last, done} !== 47'h0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0", {raddr, busy, out_valid, out_data, out_addr, out_last, done});
    end
    @(negedge clk); reset = 1'b0;
    run_dump(5'd0, 5'd31, 1'b0, -1);
  endtask

  task automatic test_write_collision();
    write_reg(5'd4, 32'h0);
    @(negedge clk); start = 1'b1; first = 5'd4; last = 5'd4; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; we = 1'b1; waddr = 5'd4; wdata = 32'h1234;
    n_cmp++;
    if (raddr !== 6'd4) begin n_fail++; $display("FAIL collide_raddr: got %0d want 4", raddr); end
    @(negedge clk); we = 1'b0;
    n_cmp++;
    if ({out_valid, out_data, out_addr, out_last} !== {1'b1, 32'h0, 5'd4, 1'b1}) begin
      n_fail++; $display("FAIL collide_word: got v%b %h @%0d l%b want v1 00000000 @4 l1",
                         out_valid, out_data, out_addr, out_last);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL collide_done: got %b want 1", done); end
    run_dump(5'd4, 5'd4, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_dump(5'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), (i == 3) ? 3 : -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_abort_and_ignored_start();
    test_reset_mid_dump();
    test_write_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
